uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receive datapath that consumes the 9x-baud sample_clk strobe from the rx sample clock generator.
//  Detects the start edge and requests sample clocks via rx_start, then majority-votes each bit and
//  deserialises LSB-first. Releases the generator via rx_done. Delivers the byte with parity/framing status.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9
//  PARITY      0   0 = none, 1 = odd, 2 = even
//  (samples per bit fixed at 9, matching the generator; not a parameter)
// PORTS
//  clk         in   1          system clock
//  rst         in   1          reset, asynchronous, active-high
//  rx_in       in   1          serial line, asynchronous to clk, idle high
//  sample_clk  in   1          1-cycle strobe, 9 per bit period, only while generator enabled
//  rx_start    out  1          1-cycle pulse: start edge seen, enable sample clock generator
//  rx_done     out  1          1-cycle pulse: frame finished or aborted, disable generator
//  rx_data     out  DATA_BITS  received word, LSB = first data bit; holds until next rx_valid
//  rx_valid    out  1          1-cycle pulse: rx_data/parity_err/frame_err updated
//  parity_err  out  1          parity mismatch for this word (0 when PARITY = 0); valid with rx_valid
//  frame_err   out  1          stop bit voted 0; valid with rx_valid
//  busy        out  1          high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, 2-FF synchroniser and edge FF preset to 1.
//  - rx_in passes a 2-FF synchroniser (rx_s), then a delay FF (rx_d). Falling edge = rx_d & ~rx_s.
//  - States: IDLE, START, DATA, PARITY, STOP.
//  - sample_cnt (4b) advances only on a sample_clk strobe: 0..8, wraps to 0 after 8. It clears on leaving IDLE.
//  - Per bit, keep the samples at indices 3, 4 and 5. The bit value is the majority of the three, decided on index 5.
//  - IDLE: on a falling edge, pulse rx_start for 1 cycle and enter START. sample_clk strobes in IDLE are ignored.
//  - START: at index 5, if the vote is 1, treat it as a false start: pulse rx_done, return to IDLE, no rx_valid.
//    Otherwise stay until the index-8 strobe, then enter DATA with bit_cnt = 0.
//  - DATA: at index 5, shift the vote in from the MSB side (LSB-first line order).
//    On the index-8 strobe, bit_cnt++. When bit_cnt reaches DATA_BITS-1, go to PARITY (PARITY != 0) or STOP.
//  - PARITY: at index 5, latch the vote. Leave on the index-8 strobe.
//    Odd: the error flag is set when (^data ^ p) == 0. Even: it is set when (^data ^ p) == 1.
//  - STOP: at index 5, the vote decides. In the next clk cycle:
//    rx_valid = 1, rx_done = 1, rx_data loaded, frame_err = ~vote, parity_err updated, state to IDLE.
//    The frame ends half a bit early, leaving margin to catch a back-to-back start edge.
//  - Latency: rx_valid/rx_done occur exactly 1 clk after the stop-bit index-5 strobe.
//  - parity_err and frame_err are registered and change only with rx_valid. rx_data is still updated on a frame error.
//  - Break (line held low): report frame_err, then IDLE. No restart until the line goes high and then falls again.
//  - rx_start fires only from IDLE. rx_start and rx_done never assert in the same cycle.
//  - Async rst mid-frame: return to the reset values immediately. No rx_done is emitted; the generator is reset by the same rst.
//  - bit_cnt width is $clog2(DATA_BITS). Shift register width is DATA_BITS. No arithmetic overflow is possible.
// TESTING  (bench: rx_clk_gen 50 MHz / 115200 -> strobe every 48 clk, bit = 432 clk; DATA_BITS = 8)
//  1. 8N1 frame 0xA5 -> exactly one rx_start, then one rx_valid with rx_data = 0xA5, parity_err = 0, frame_err = 0, one rx_done.
//  2. rx_in low for 100 clk, then high -> rx_start, then rx_done at the START index-5 vote, no rx_valid, back in IDLE.
//  3. 0x3C with one-strobe-wide low glitches in data bits 2 and 6 -> rx_data = 0x3C, no errors.
//  4. PARITY = 2, byte 0x03 sent with parity bit 1 -> parity_err = 1. The same byte with parity bit 0 -> parity_err = 0.
//  5. 0x55 with stop bit driven 0 -> rx_valid, rx_data = 0x55, frame_err = 1. Line then held low 5 bit times -> no new rx_start.
//  6. Bytes 0x00 then 0xFF with zero idle gap -> two rx_valid, data correct. Also assert rst mid-byte: outputs 0, next 0x81 received cleanly.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Receiver-side bundle: serial line and sample strobe in, handshake pulses and word/status out.
// master = the receiver core, slave = the generator/consumer side.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_in;
    logic                 sample_clk;
    logic                 rx_start;
    logic                 rx_done;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx_in, sample_clk,
        output rx_start, rx_done, rx_data, rx_valid, parity_err, frame_err, busy
    );

    modport slave (
        output rx_in, sample_clk,
        input  rx_start, rx_done, rx_data, rx_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: majority-votes 9x oversampled bits and deserialises LSB-first.
// Latency: rx_valid/rx_done one clk after the stop-bit index-5 strobe.
// No backpressure: rx_valid is a pulse and rx_data holds until the next word.
module uart_rx_core #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_core_if.master rx
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state;
    logic                 rx_m, rx_s, rx_d;
    logic [3:0]           sample_cnt;
    logic                 s3, s4;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 fall, vote, at5, at8, pe_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx.rx_in;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_comb begin
        fall = rx_d & ~rx_s;
        vote = (s3 & s4) | (s3 & rx_s) | (s4 & rx_s);
        at5  = rx.sample_clk && (sample_cnt == 4'd5);
        at8  = rx.sample_clk && (sample_cnt == 4'd8);
        pe_next = 1'b0;
        if (PARITY == 1)
            pe_next = ~(^shreg ^ par_bit);
        else if (PARITY == 2)
            pe_next = ^shreg ^ par_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            sample_cnt    <= 4'd0;
            s3            <= 1'b0;
            s4            <= 1'b0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            rx.rx_start   <= 1'b0;
            rx.rx_done    <= 1'b0;
            rx.rx_data    <= '0;
            rx.rx_valid   <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.busy       <= 1'b0;
        end else begin
            rx.rx_start <= 1'b0;
            rx.rx_done  <= 1'b0;
            rx.rx_valid <= 1'b0;

            // Strobes only count while a frame is in flight; IDLE ignores them.
            if (state != S_IDLE && rx.sample_clk) begin
                sample_cnt <= (sample_cnt == 4'd8) ? 4'd0 : sample_cnt + 4'd1;
                if (sample_cnt == 4'd3) s3 <= rx_s;
                if (sample_cnt == 4'd4) s4 <= rx_s;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        rx.rx_start <= 1'b1;
                        rx.busy     <= 1'b1;
                        sample_cnt  <= 4'd0;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    if (at5 && vote) begin
                        rx.rx_done <= 1'b1;
                        rx.busy    <= 1'b0;
                        sample_cnt <= 4'd0;
                        state      <= S_IDLE;
                    end else if (at8) begin
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (at5)
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (at8) begin
                        if (bit_cnt == LAST_BIT)
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (at5) par_bit <= vote;
                    if (at8) state <= S_STOP;
                end
                S_STOP: begin
                    // Finish at the stop-bit centre so a back-to-back start edge is not missed.
                    if (at5) begin
                        rx.rx_valid   <= 1'b1;
                        rx.rx_done    <= 1'b1;
                        rx.rx_data    <= shreg;
                        rx.frame_err  <= ~vote;
                        rx.parity_err <= pe_next;
                        rx.busy       <= 1'b0;
                        sample_cnt    <= 4'd0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 8N1 instance plus an even-parity instance, each fed by a 48-clk strobe generator.
module tb_uart_rx_core;
    localparam int BIT_T = 432;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    uart_rx_core_if #(.DATA_BITS(8)) uif0 ();
    uart_rx_core_if #(.DATA_BITS(8)) uif1 ();

    uart_rx_core #(.DATA_BITS(8), .PARITY(0)) dut0 (.clk(clk), .rst(rst), .rx(uif0.master));
    uart_rx_core #(.DATA_BITS(8), .PARITY(2)) dut1 (.clk(clk), .rst(rst), .rx(uif1.master));

    // Sample clock generators: enabled by rx_start, released by rx_done, strobe mid-period.
    logic g0_en, g1_en;
    int   g0_cnt, g1_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            g0_en <= 1'b0; g0_cnt <= 0; uif0.sample_clk <= 1'b0;
        end else begin
            if (uif0.rx_start) begin g0_en <= 1'b1; g0_cnt <= 0; end
            else if (uif0.rx_done) g0_en <= 1'b0;
            else if (g0_en) g0_cnt <= (g0_cnt == 47) ? 0 : g0_cnt + 1;
            uif0.sample_clk <= g0_en && (g0_cnt == 23) && !uif0.rx_done;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            g1_en <= 1'b0; g1_cnt <= 0; uif1.sample_clk <= 1'b0;
        end else begin
            if (uif1.rx_start) begin g1_en <= 1'b1; g1_cnt <= 0; end
            else if (uif1.rx_done) g1_en <= 1'b0;
            else if (g1_en) g1_cnt <= (g1_cnt == 47) ? 0 : g1_cnt + 1;
            uif1.sample_clk <= g1_en && (g1_cnt == 23) && !uif1.rx_done;
        end
    end

    // Event monitors: pulse counts, received-word log, protocol violations.
    int         st0 = 0, dn0 = 0, vl0 = 0, bad0 = 0;
    int         st1 = 0, dn1 = 0, vl1 = 0, bad1 = 0;
    logic       prev_s0 = 1'b0, prev_s1 = 1'b0;
    logic [7:0] log0 [0:63];

    always @(posedge clk) begin
        prev_s0 <= uif0.sample_clk;
        if (uif0.rx_start) st0 <= st0 + 1;
        if (uif0.rx_done)  dn0 <= dn0 + 1;
        if (uif0.rx_valid) begin
            log0[vl0 % 64] <= uif0.rx_data;
            vl0 <= vl0 + 1;
        end
        if ((uif0.rx_valid && !prev_s0) || (uif0.rx_start && uif0.rx_done))
            bad0 <= bad0 + 1;
    end

    always @(posedge clk) begin
        prev_s1 <= uif1.sample_clk;
        if (uif1.rx_start) st1 <= st1 + 1;
        if (uif1.rx_done)  dn1 <= dn1 + 1;
        if (uif1.rx_valid) vl1 <= vl1 + 1;
        if ((uif1.rx_valid && !prev_s1) || (uif1.rx_start && uif1.rx_done))
            bad1 <= bad1 + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int d, input logic v);
        if (d == 0) uif0.rx_in = v;
        else        uif1.rx_in = v;
    endtask

    task automatic send_bit(input int d, input logic v, input logic glitch);
        set_line(d, v);
        if (glitch) begin
            repeat (196) @(negedge clk);
            set_line(d, 1'b0);
            repeat (48) @(negedge clk);
            set_line(d, v);
            repeat (188) @(negedge clk);
        end else begin
            repeat (BIT_T) @(negedge clk);
        end
    endtask

    // par < 0 means no parity bit on the line.
    task automatic send_frame(input int d, input logic [7:0] b, input int par,
                              input logic stop, input logic [7:0] gmask);
        send_bit(d, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d, b[i], gmask[i]);
        if (par >= 0) send_bit(d, par[0], 1'b0);
        send_bit(d, stop, 1'b0);
    endtask

    int s, dn, v;

    initial begin
        uif0.rx_in = 1'b1;
        uif1.rx_in = 1'b1;
        #5 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_valid", uif0.rx_valid, 0);
        chk("rst_start", uif0.rx_start, 0);
        chk("rst_busy",  uif0.busy, 0);
        chk("rst_data",  uif0.rx_data, 0);
        chk("rst_ferr",  uif0.frame_err, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Clean 8N1 frame
        s = st0; dn = dn0; v = vl0;
        send_frame(0, 8'hA5, -1, 1'b1, 8'h00);
        repeat (BIT_T) @(negedge clk);
        chk("t1_start", st0 - s, 1);
        chk("t1_done",  dn0 - dn, 1);
        chk("t1_valid", vl0 - v, 1);
        chk("t1_data",  uif0.rx_data, 8'hA5);
        chk("t1_perr",  uif0.parity_err, 0);
        chk("t1_ferr",  uif0.frame_err, 0);
        chk("t1_busy",  uif0.busy, 0);

        // False start: 100-clk low pulse
        s = st0; dn = dn0; v = vl0;
        set_line(0, 1'b0);
        repeat (100) @(negedge clk);
        set_line(0, 1'b1);
        repeat (600) @(negedge clk);
        chk("t2_start", st0 - s, 1);
        chk("t2_done",  dn0 - dn, 1);
        chk("t2_valid", vl0 - v, 0);
        chk("t2_busy",  uif0.busy, 0);

        // Single-sample glitches in data bits 2 and 6 are voted out
        v = vl0;
        send_frame(0, 8'h3C, -1, 1'b1, 8'h44);
        repeat (BIT_T) @(negedge clk);
        chk("t3_valid", vl0 - v, 1);
        chk("t3_data",  uif0.rx_data, 8'h3C);
        chk("t3_ferr",  uif0.frame_err, 0);

        // Framing error, then a held-low break must not restart
        v = vl0;
        send_frame(0, 8'h55, -1, 1'b0, 8'h00);
        chk("t5_valid", vl0 - v, 1);
        chk("t5_data",  uif0.rx_data, 8'h55);
        chk("t5_ferr",  uif0.frame_err, 1);
        s = st0;
        repeat (5 * BIT_T) @(negedge clk);
        chk("t5_break_start", st0 - s, 0);
        set_line(0, 1'b1);
        repeat (2 * BIT_T) @(negedge clk);
        chk("t5_release_start", st0 - s, 0);
        chk("t5_busy", uif0.busy, 0);

        // Back-to-back frames with no idle gap
        v = vl0;
        send_frame(0, 8'h00, -1, 1'b1, 8'h00);
        send_frame(0, 8'hFF, -1, 1'b1, 8'h00);
        repeat (BIT_T) @(negedge clk);
        chk("t6_valid", vl0 - v, 2);
        chk("t6_first",  log0[v % 64], 8'h00);
        chk("t6_second", log0[(v + 1) % 64], 8'hFF);
        chk("t6_ferr", uif0.frame_err, 0);

        // Reset in the middle of a frame, then a clean frame
        send_bit(0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        send_bit(0, 1'b0, 1'b0);
        rst = 1'b1;
        set_line(0, 1'b1);
        repeat (3) @(negedge clk);
        chk("t6_rst_busy",  uif0.busy, 0);
        chk("t6_rst_data",  uif0.rx_data, 0);
        chk("t6_rst_valid", uif0.rx_valid, 0);
        rst = 1'b0;
        repeat (2 * BIT_T) @(negedge clk);
        v = vl0;
        send_frame(0, 8'h81, -1, 1'b1, 8'h00);
        repeat (BIT_T) @(negedge clk);
        chk("t6_post_valid", vl0 - v, 1);
        chk("t6_post_data",  uif0.rx_data, 8'h81);
        chk("t6_post_ferr",  uif0.frame_err, 0);

        // Even parity: 0x03 has even data parity, so parity bit 1 is wrong
        v = vl1;
        send_frame(1, 8'h03, 1, 1'b1, 8'h00);
        repeat (BIT_T) @(negedge clk);
        chk("t4_perr_bad",  uif1.parity_err, 1);
        chk("t4_data",      uif1.rx_data, 8'h03);
        chk("t4_ferr",      uif1.frame_err, 0);
        send_frame(1, 8'h03, 0, 1'b1, 8'h00);
        repeat (BIT_T) @(negedge clk);
        chk("t4_perr_good", uif1.parity_err, 0);
        chk("t4_valid", vl1 - v, 2);
        chk("t4_start_done", st1 - dn1, 0);

        chk("dut0_protocol", bad0, 0);
        chk("dut1_protocol", bad1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
